dram_cmd_scheduler: RTL and testbench
=====================================

DRAM_CMD_SCHEDULER -- requirements
Module: dram_cmd_scheduler

Interface
REQ-001 SHALL have parameter T_RP, default 4: PRE-to-ACT spacing in clocks, legal range 2..15.
REQ-002 SHALL have parameter T_RCD, default 4: ACT-to-RD/WR spacing in clocks, legal range 2..15.
REQ-003 SHALL have parameter T_CL, default 6: RD/WR-to-response spacing in clocks, legal range 2..15.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 1 bit: queue head holds a request.
REQ-007 SHALL have port req_ready, output, 1 bit: scheduler accepts the head this cycle.
REQ-008 SHALL have port req_op, input, 2 bits: 0 = data read, 1 = data write, 2 = instruction fetch, 3 = treated as read.
REQ-009 SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 SHALL have port cmd_valid, output, 1 bit: command issued this cycle.
REQ-011 SHALL have port cmd, output, 3 bits: 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE.
REQ-012 SHALL have ports cmd_bank (2 bits), cmd_row (16 bits) and cmd_col (10 bits), all outputs, carrying the target of cmd.
REQ-013 SHALL have ports resp_valid (1 bit), resp_op (2 bits) and resp_addr (32 bits), all outputs: completion pulse carrying the original op and address.

Function
REQ-014 SHALL decode the address as col = req_addr[11:2], bank = req_addr[13:12], row = req_addr[29:14]; bits [31:30] and [1:0] are ignored.
REQ-015 SHALL keep an open-row table of 4 entries, each an open flag plus a 16-bit row.
- ACT sets open and row for its bank.
- PRE clears open for its bank.
REQ-016 SHALL use states IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, RW, WAIT_CL.
REQ-017 SHALL drive req_ready = 1 only in IDLE; a transfer occurs when req_valid && req_ready at a clock edge.
- On transfer, op, addr and the decoded fields are latched.
- Next state: RW on a row hit (bank open, same row); ACT if the bank is closed; PRE on a conflict (bank open, different row).
REQ-018 SHALL assert cmd_valid for exactly one cycle in each of PRE, ACT and RW, and never otherwise.
- cmd = 0 and cmd_bank/row/col = 0 whenever cmd_valid = 0.
- RW issues WR when op = 1 and RD otherwise.
REQ-019 SHALL use a 4-bit down-counter for command spacing.
- ACT issues exactly T_RP cycles after PRE.
- RD/WR issues exactly T_RCD cycles after ACT.
- resp_valid pulses for one cycle exactly T_CL cycles after RD/WR.
REQ-020 SHALL return to IDLE in the cycle after resp_valid; req_ready is high in that cycle.
REQ-021 SHALL process strictly in order, one request at a time; req_op and req_addr are ignored outside a transfer.
REQ-022 SHALL hold resp_op and resp_addr equal to the latched request while resp_valid = 1, and 0 otherwise.
REQ-023 SHALL leave the row open after RD/WR (open-page policy); no auto-precharge and no refresh.
REQ-024 SHALL not stall: a request accepted at edge n has a fixed latency by its hit/closed/conflict class, independent of req_valid afterwards.

Reset
REQ-025 SHALL, while rst = 1, force state to IDLE, clear all open flags, zero the counter and drive every output to 0 except req_ready.
REQ-026 SHALL drive req_ready = 0 during reset and 1 in the first cycle after rst deasserts.
REQ-027 SHALL, on reset mid-operation, abort the request with no further cmd_valid or resp_valid and no table update.

Verification
REQ-028 SHALL pass closed-bank read: reset, op=0, addr=0x0000_1000, accepted at edge 0 -> ACT bank1 row0 at cycle 1; RD col0 at cycle 5; resp_valid with addr 0x0000_1000 at cycle 11; req_ready at cycle 12.
REQ-029 SHALL pass row hit: follow-up op=1, addr=0x0000_1004 accepted at edge 0 -> WR bank1 col1 at cycle 1; resp at cycle 7; no ACT or PRE issued.
REQ-030 SHALL pass row conflict: after the above, op=2, addr=0x0000_5000 (bank1 row1) -> PRE bank1 at 1; ACT row1 at 5; RD at 9; resp op=2 at 15.
REQ-031 SHALL pass bank independence: open bank0 row 3 and bank2 row 7, then read bank0 row 3 -> RD with no PRE, and bank2 stays open.
REQ-032 SHALL pass reset mid-op: assert rst during WAIT_RCD -> no RD and no resp; after reset, the same address issues ACT again (bank closed).
REQ-033 SHALL pass back-to-back: req_valid held high with 3 hit requests -> accepts at edges 0, 8 and 16; exactly one cmd per request.

Source files
------------

// File: rtl/dram_cmd_scheduler.sv
// dram_cmd_scheduler: in-order, one-at-a-time DRAM command sequencer.
// Decodes each accepted request into bank/row/col, consults a per-bank
// open-row table and walks PRE -> ACT -> RD/WR as needed, then returns a
// completion pulse T_CL cycles after the column command. Open-page policy.
module dram_cmd_scheduler #(
  parameter int T_RP  = 4,
  parameter int T_RCD = 4,
  parameter int T_CL  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  output logic        cmd_valid,
  output logic [2:0]  cmd,
  output logic [1:0]  cmd_bank,
  output logic [15:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic        resp_valid,
  output logic [1:0]  resp_op,
  output logic [31:0] resp_addr
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PRE      = 3'd1;
  localparam logic [2:0] S_WAIT_RP  = 3'd2;
  localparam logic [2:0] S_ACT      = 3'd3;
  localparam logic [2:0] S_WAIT_RCD = 3'd4;
  localparam logic [2:0] S_RW       = 3'd5;
  localparam logic [2:0] S_WAIT_CL  = 3'd6;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;

  // The command state itself takes one cycle, so the wait states run one
  // cycle short of the spacing; the CL wait ends on the response cycle.
  localparam logic [3:0] RP_LOAD  = 4'(T_RP - 2);
  localparam logic [3:0] RCD_LOAD = 4'(T_RCD - 2);
  localparam logic [3:0] CL_LOAD  = 4'(T_CL - 1);

  logic [2:0]  state;
  logic [3:0]  cnt;
  logic [1:0]  op_q;
  logic [31:0] addr_q;
  logic [3:0]  bank_open;
  logic [15:0] open_row [4];

  logic [1:0]  in_bank;
  logic [15:0] in_row;
  logic        in_open;
  logic        in_hit;
  logic [1:0]  q_bank;
  logic [15:0] q_row;
  logic [9:0]  q_col;

  assign in_bank = req_addr[13:12];
  assign in_row  = req_addr[29:14];
  assign in_open = bank_open[in_bank];
  assign in_hit  = in_open && (open_row[in_bank] == in_row);

  assign q_bank = addr_q[13:12];
  assign q_row  = addr_q[29:14];
  assign q_col  = addr_q[11:2];

  // Sequencer state, spacing counter, latched request and open-row table
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      bank_open <= '0;
      for (int i = 0; i < 4; i++) open_row[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            addr_q <= req_addr;
            if (in_hit)       state <= S_RW;
            else if (in_open) state <= S_PRE;
            else              state <= S_ACT;
          end
        end
        S_PRE: begin
          bank_open[q_bank] <= 1'b0;
          cnt               <= RP_LOAD;
          state             <= S_WAIT_RP;
        end
        S_WAIT_RP: begin
          if (cnt == 4'd0) state <= S_ACT;
          else             cnt   <= cnt - 4'd1;
        end
        S_ACT: begin
          bank_open[q_bank] <= 1'b1;
          open_row[q_bank]  <= q_row;
          cnt               <= RCD_LOAD;
          state             <= S_WAIT_RCD;
        end
        S_WAIT_RCD: begin
          if (cnt == 4'd0) state <= S_RW;
          else             cnt   <= cnt - 4'd1;
        end
        S_RW: begin
          cnt   <= CL_LOAD;
          state <= S_WAIT_CL;
        end
        S_WAIT_CL: begin
          if (cnt == 4'd0) state <= S_IDLE;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Command, response and handshake outputs decoded from the current state
  always_comb begin
    cmd_valid  = 1'b0;
    cmd        = CMD_NOP;
    cmd_bank   = '0;
    cmd_row    = '0;
    cmd_col    = '0;
    resp_valid = 1'b0;
    resp_op    = '0;
    resp_addr  = '0;
    req_ready  = (state == S_IDLE) && !rst;
    case (state)
      S_PRE: begin
        cmd_valid = 1'b1;
        cmd       = CMD_PRE;
        cmd_bank  = q_bank;
      end
      S_ACT: begin
        cmd_valid = 1'b1;
        cmd       = CMD_ACT;
        cmd_bank  = q_bank;
        cmd_row   = q_row;
      end
      S_RW: begin
        cmd_valid = 1'b1;
        cmd       = (op_q == 2'd1) ? CMD_WR : CMD_RD;
        cmd_bank  = q_bank;
        cmd_row   = q_row;
        cmd_col   = q_col;
      end
      S_WAIT_CL: begin
        if (cnt == 4'd0) begin
          resp_valid = 1'b1;
          resp_op    = op_q;
          resp_addr  = addr_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// tb_dram_cmd_scheduler: table-driven and randomized checks of the DRAM
// command scheduler against a latency-arithmetic reference model.
module tb_dram_cmd_scheduler;

  localparam int T_RP  = 4;
  localparam int T_RCD = 4;
  localparam int T_CL  = 6;
  localparam int MAXC  = 4096;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [1:0]  cmd_bank;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        resp_valid;
  logic [1:0]  resp_op;
  logic [31:0] resp_addr;

  int total;
  int bad;
  int k;
  int readyAt;

  // Expected outputs per cycle; cycle k lies between edge k-1 and edge k
  bit [2:0]  expCmd      [MAXC];
  bit [1:0]  expBank     [MAXC];
  bit [15:0] expRow      [MAXC];
  bit [9:0]  expCol      [MAXC];
  bit        expResp     [MAXC];
  bit [1:0]  expRespOp   [MAXC];
  bit [31:0] expRespAddr [MAXC];

  bit        mOpen [4];
  bit [15:0] mRow  [4];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    int          firstCmd;
    int          rwAt;
    int          respAt;
  } vec_t;

  vec_t vecs [8];

  logic [1:0]  rHi;
  logic [1:0]  rBank;
  logic [15:0] rRow;
  logic [9:0]  rCol;
  int          fc;
  int          rw;
  int          rs;

  dram_cmd_scheduler #(.T_RP(T_RP), .T_RCD(T_RCD), .T_CL(T_CL)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_bank  (cmd_bank),
    .cmd_row   (cmd_row),
    .cmd_col   (cmd_col),
    .resp_valid(resp_valid),
    .resp_op   (resp_op),
    .resp_addr (resp_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s (cycle %0d): got 0x%0h, want 0x%0h", name, k, act, exp);
    end
  endtask

  // Model: accepted at edge e, the request's commands land at fixed offsets
  function automatic void schedule(int e, logic [1:0] op, logic [31:0] addr);
    logic [1:0]  b;
    logic [15:0] r;
    int          actAt;
    int          rwAt;
    b = addr[13:12];
    r = addr[29:14];
    if (mOpen[b] && mRow[b] == r) begin
      rwAt = e + 1;
    end else begin
      if (mOpen[b]) begin
        expCmd[e + 1]  = 3'd4;
        expBank[e + 1] = b;
        actAt = e + 1 + T_RP;
      end else begin
        actAt = e + 1;
      end
      expCmd[actAt]  = 3'd1;
      expBank[actAt] = b;
      expRow[actAt]  = r;
      rwAt = actAt + T_RCD;
    end
    expCmd[rwAt]             = (op == 2'd1) ? 3'd3 : 3'd2;
    expBank[rwAt]            = b;
    expRow[rwAt]             = r;
    expCol[rwAt]             = addr[11:2];
    expResp[rwAt + T_CL]     = 1'b1;
    expRespOp[rwAt + T_CL]   = op;
    expRespAddr[rwAt + T_CL] = addr;
    readyAt  = rwAt + T_CL + 1;
    mOpen[b] = 1'b1;
    mRow[b]  = r;
  endfunction

  task automatic checkCycle();
    bit [2:0] ec;
    ec = expCmd[k];
    checkOutput("cmd_valid", {31'b0, cmd_valid}, {31'b0, ec != 3'd0});
    checkOutput("cmd", {29'b0, cmd}, {29'b0, ec});
    checkOutput("cmd_bank", {30'b0, cmd_bank}, {30'b0, expBank[k]});
    if (ec != 3'd4) checkOutput("cmd_row", {16'b0, cmd_row}, {16'b0, expRow[k]});
    if (ec != 3'd4 && ec != 3'd1) checkOutput("cmd_col", {22'b0, cmd_col}, {22'b0, expCol[k]});
    checkOutput("resp_valid", {31'b0, resp_valid}, {31'b0, expResp[k]});
    checkOutput("resp_op", {30'b0, resp_op}, {30'b0, expRespOp[k]});
    checkOutput("resp_addr", resp_addr, expRespAddr[k]);
    checkOutput("req_ready", {31'b0, req_ready}, {31'b0, (rst !== 1'b1) && (k >= readyAt)});
  endtask

  task automatic step();
    if (req_valid && rst !== 1'b1 && k >= readyAt) schedule(k, req_op, req_addr);
    @(posedge clk);
    k++;
    @(negedge clk);
    checkCycle();
  endtask

  task automatic doReset();
    rst = 1'b1;
    for (int i = k; i < k + 64 && i < MAXC; i++) begin
      expCmd[i]      = '0;
      expBank[i]     = '0;
      expRow[i]      = '0;
      expCol[i]      = '0;
      expResp[i]     = '0;
      expRespOp[i]   = '0;
      expRespAddr[i] = '0;
    end
    for (int b = 0; b < 4; b++) mOpen[b] = 1'b0;
    readyAt = 1 << 30;
    #1 checkCycle();
    step();
    step();
    rst = 1'b0;
    readyAt = k;
    #1 checkCycle();
  endtask

  task automatic applyStimulus(input vec_t v, output int firstCmd, output int rwRel, output int respRel);
    int e;
    firstCmd  = -1;
    rwRel     = -1;
    respRel   = -1;
    req_valid = 1'b1;
    req_op    = v.op;
    req_addr  = v.addr;
    e = k;
    step();
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_addr  = $urandom;
    for (int i = 0; i < 60; i++) begin
      if (cmd_valid && firstCmd < 0) firstCmd = int'(cmd);
      if (cmd_valid && (cmd == 3'd2 || cmd == 3'd3)) rwRel = k - e;
      if (resp_valid) begin
        respRel = k - e;
        break;
      end
      step();
    end
    step();
  endtask

  initial begin
    logic [31:0] bAddr [3];
    logic [1:0]  bOp   [3];
    int          acc   [3];
    int          idx;
    int          cmds;
    int          seen;
    bit          took;
    int          accEdge;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_addr  = '0;
    total     = 0;
    bad       = 0;
    k         = 0;
    readyAt   = 1 << 30;

    vecs[0] = '{2'd0, 32'h0000_1000, 1, 5, 11};
    vecs[1] = '{2'd1, 32'h0000_1004, 3, 1, 7};
    vecs[2] = '{2'd2, 32'h0000_5000, 4, 9, 15};
    vecs[3] = '{2'd0, 32'h0000_C000, 1, 5, 11};
    vecs[4] = '{2'd0, 32'h0001_E000, 1, 5, 11};
    vecs[5] = '{2'd3, 32'h0000_C014, 2, 1, 7};
    vecs[6] = '{2'd1, 32'h0001_E008, 3, 1, 7};
    vecs[7] = '{2'd0, 32'hC000_1004, 4, 9, 15};

    @(negedge clk);
    doReset();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], fc, rw, rs);
      checkOutput($sformatf("vec%0d first cmd", i), fc, vecs[i].firstCmd);
      checkOutput($sformatf("vec%0d rw cycle", i), rw, vecs[i].rwAt);
      checkOutput($sformatf("vec%0d resp cycle", i), rs, vecs[i].respAt);
    end

    bAddr[0] = 32'h0000_C000; bOp[0] = 2'd0;
    bAddr[1] = 32'h0000_C004; bOp[1] = 2'd1;
    bAddr[2] = 32'h0000_C008; bOp[2] = 2'd0;
    acc[0] = -100; acc[1] = -100; acc[2] = -100;
    idx  = 0;
    cmds = 0;
    req_valid = 1'b1;
    req_op    = bOp[0];
    req_addr  = bAddr[0];
    for (int i = 0; i < 40; i++) begin
      took    = req_valid && req_ready;
      accEdge = k;
      step();
      if (cmd_valid) cmds++;
      if (took && idx < 3) begin
        acc[idx] = accEdge;
        idx++;
        if (idx < 3) begin
          req_op   = bOp[idx];
          req_addr = bAddr[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    checkOutput("b2b accepts", idx, 3);
    checkOutput("b2b second accept edge", acc[1] - acc[0], 8);
    checkOutput("b2b third accept edge", acc[2] - acc[0], 16);
    checkOutput("b2b cmd count", cmds, 3);

    req_valid = 1'b1;
    req_op    = 2'd0;
    req_addr  = 32'h0002_7000;
    step();
    req_valid = 1'b0;
    step();
    step();
    doReset();
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (cmd_valid || resp_valid) seen++;
    end
    checkOutput("reset mid-op quiet", seen, 0);
    applyStimulus('{2'd0, 32'h0002_7000, 1, 5, 11}, fc, rw, rs);
    checkOutput("after reset first cmd", fc, 1);
    checkOutput("after reset resp cycle", rs, 11);

    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom % 3) != 0;
      req_op    = 2'($urandom);
      rHi       = 2'($urandom);
      rBank     = 2'($urandom);
      rRow      = 16'($urandom % 3);
      rCol      = 10'($urandom);
      req_addr  = {rHi, rRow, rBank, rCol, 2'($urandom)};
      if ($urandom % 120 == 0) doReset();
      else step();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 50; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
